// File: rtl/proc_seq_core_if.sv
// proc_seq_core_if: instruction/data memory, register bank and ALU connections
// of the sequencer. master = core side, slave = environment side.
interface proc_seq_core_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned REG_AW = 4
);
    // instruction memory
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [DATA_W-1:0] imem_rdata;
    // data memory
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ready;
    logic [DATA_W-1:0] dmem_rdata;
    // register bank
    logic [REG_AW-1:0] rf_raddr1;
    logic [REG_AW-1:0] rf_raddr2;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    // ALU
    logic [3:0]        alu_op;
    logic [2:0]        alu_sr;
    logic [15:0]       alu_imm;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata,
        output rf_raddr1, rf_raddr2,
        input  rf_rdata1, rf_rdata2,
        output rf_we, rf_waddr, rf_wdata,
        output alu_op, alu_sr, alu_imm, alu_a, alu_b,
        input  alu_result, alu_flags
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata,
        input  rf_raddr1, rf_raddr2,
        output rf_rdata1, rf_rdata2,
        input  rf_we, rf_waddr, rf_wdata,
        input  alu_op, alu_sr, alu_imm, alu_a, alu_b,
        output alu_result, alu_flags
    );
endinterface

// File: rtl/proc_seq_core.sv
// proc_seq_core: multi-cycle sequencer of the 32-bit processor.
// Owns PC, IR and NZCV flags and runs FETCH/DECODE/EXEC/MEM/WB/HALT,
// driving memories, register bank and ALU through proc_seq_core_if.
module proc_seq_core #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       REG_AW   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    proc_seq_core_if.master bus,
    output logic [3:0]      flags,
    output logic            halted
);
    localparam logic [3:0] OP_HALT = 4'hC;
    localparam logic [3:0] OP_LDR  = 4'hD;
    localparam logic [3:0] OP_STR  = 4'hE;
    localparam logic [3:0] OP_B    = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic [DATA_W-1:0] r_result;
    logic [3:0]        r_flags;
    // Low while in reset and for the first cycle after; keeps every
    // request output at 0 during reset even though the state is FETCH.
    logic              r_active;

    logic [3:0]        w_cond;
    logic [3:0]        w_op;
    logic              w_s;
    logic              w_is_alu;
    logic              w_cond_pass;
    logic              w_fetch_done;
    logic              w_mem_done;
    logic              w_imem_req;
    logic              w_dmem_req;
    logic              w_dmem_we;
    logic              w_rf_we;
    logic              w_halted;
    logic [ADDR_W-1:0] w_boff;
    logic              w_n;
    logic              w_z;
    logic              w_c;
    logic              w_v;

    assign w_cond   = r_ir[31:28];
    assign w_op     = r_ir[27:24];
    assign w_s      = r_ir[23];
    assign w_is_alu = (w_op <= 4'hB);
    assign w_boff   = ADDR_W'($signed(r_ir[18:3]));

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    assign w_fetch_done = (r_state == S_FETCH) && r_active && bus.imem_ready;
    assign w_mem_done   = (r_state == S_MEM) && bus.dmem_ready;

    // Condition code evaluation against the current NZCV register
    always_comb begin
        w_cond_pass = 1'b0;
        unique case (w_cond)
            4'h0:    w_cond_pass = w_z;
            4'h1:    w_cond_pass = !w_z;
            4'h2:    w_cond_pass = w_c;
            4'h3:    w_cond_pass = !w_c;
            4'h4:    w_cond_pass = w_n;
            4'h5:    w_cond_pass = !w_n;
            4'h6:    w_cond_pass = w_v;
            4'h7:    w_cond_pass = !w_v;
            4'h8:    w_cond_pass = w_c && !w_z;
            4'h9:    w_cond_pass = !w_c || w_z;
            4'hA:    w_cond_pass = (w_n == w_v);
            4'hB:    w_cond_pass = (w_n != w_v);
            4'hC:    w_cond_pass = !w_z && (w_n == w_v);
            4'hD:    w_cond_pass = w_z || (w_n != w_v);
            4'hE:    w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state strobes
    always_comb begin
        w_next     = r_state;
        w_imem_req = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_rf_we    = 1'b0;
        w_halted   = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_imem_req = r_active;
                if (w_fetch_done) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!w_cond_pass) begin
                    w_next = S_FETCH;
                end else if (w_op == OP_HALT) begin
                    w_next = S_HALT;
                end else if ((w_op == OP_LDR) || (w_op == OP_STR)) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next = w_is_alu ? S_WB : S_FETCH;
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (w_op == OP_STR);
                if (w_mem_done) begin
                    w_next = (w_op == OP_STR) ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                w_rf_we = 1'b1;
                w_next  = S_FETCH;
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // PC, IR, operand latches and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
        end else begin
            r_active <= 1'b1;
            if (w_fetch_done) begin
                r_ir <= bus.imem_rdata;
                r_pc <= r_pc + ADDR_W'(1);
            end
            if (r_state == S_DECODE) begin
                r_opa <= bus.rf_rdata1;
                r_opb <= bus.rf_rdata2;
            end
            if (r_state == S_EXEC) begin
                if (w_is_alu) begin
                    r_result <= bus.alu_result;
                end else if (w_op == OP_B) begin
                    r_pc <= r_pc + w_boff;
                end
            end
            if (w_mem_done && (w_op == OP_LDR)) begin
                r_result <= bus.dmem_rdata;
            end
        end
    end

    // NZCV register: written only by ALU instructions with s=1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if ((r_state == S_EXEC) && w_is_alu && w_s) begin
            r_flags <= bus.alu_flags;
        end
    end

    assign bus.imem_req   = w_imem_req;
    assign bus.imem_addr  = r_pc;
    assign bus.dmem_req   = w_dmem_req;
    assign bus.dmem_we    = w_dmem_we;
    assign bus.dmem_addr  = r_opa[ADDR_W-1:0];
    assign bus.dmem_wdata = r_opb;
    assign bus.rf_raddr1  = r_ir[18:15];
    assign bus.rf_raddr2  = r_ir[14:11];
    assign bus.rf_we      = w_rf_we;
    assign bus.rf_waddr   = r_ir[22:19];
    assign bus.rf_wdata   = r_result;
    assign bus.alu_op     = r_ir[27:24];
    assign bus.alu_sr     = r_ir[2:0];
    assign bus.alu_imm    = r_ir[18:3];
    assign bus.alu_a      = r_opa;
    assign bus.alu_b      = r_opb;
    assign flags          = r_flags;
    assign halted         = w_halted;
endmodule

// File: tb/tb_proc_seq_core.sv
// tb_proc_seq_core: directed program runs against memory, register bank and
// ALU models; register writes and data accesses checked from scoreboards.
module tb_proc_seq_core;
    localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_AL = 4'hE, C_NV = 4'hF;
    localparam logic [3:0] O_ADD = 4'h0, O_SUB = 4'h1, O_HALT = 4'hC;
    localparam logic [3:0] O_LDR = 4'hD, O_STR = 4'hE, O_B = 4'hF;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  fl;
    } wb_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
        logic [7:0]  ncyc;
    } dm_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] flags;
    logic halted;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int dcnt = 0;
    int dwait = 3;
    int dreq_n = 0;
    int n_store = 0;
    logic imem_en = 1'b1;
    logic imem_force = 1'b0;

    logic [31:0] imem [0:65535];
    logic [31:0] dmem [0:255] = '{64: 32'hDEADBEEF, default: 32'h0};
    logic [31:0] regs [0:15] = '{1: 32'd5, 2: 32'd7, 7: 32'h77, 8: 32'h40, default: 32'h0};

    wb_t wb_q[$];
    dm_t dm_q[$];
    logic [15:0] fa_q[$];
    int ft_q[$];

    logic [15:0] d_addr0;
    logic [31:0] d_wdata0;

    proc_seq_core_if #(.DATA_W(32), .ADDR_W(16), .REG_AW(4)) bus ();

    proc_seq_core #(
        .DATA_W(32), .ADDR_W(16), .REG_AW(4), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .flags(flags),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // environment models
    assign bus.imem_ready = (bus.imem_req & imem_en) | imem_force;
    assign bus.imem_rdata = imem[bus.imem_addr];
    assign bus.dmem_ready = bus.dmem_req && (dcnt == dwait - 1);
    assign bus.dmem_rdata = dmem[bus.dmem_addr[7:0]];
    assign bus.rf_rdata1  = regs[bus.rf_raddr1];
    assign bus.rf_rdata2  = regs[bus.rf_raddr2];

    always_comb begin
        logic [32:0] t;
        t = '0;
        bus.alu_result = '0;
        bus.alu_flags  = '0;
        case (bus.alu_op)
            O_ADD: begin
                t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                bus.alu_result = t[31:0];
                bus.alu_flags = {t[31], t[31:0] == 32'd0, t[32],
                                 (bus.alu_a[31] == bus.alu_b[31]) && (t[31] != bus.alu_a[31])};
            end
            O_SUB: begin
                t[31:0] = bus.alu_a - bus.alu_b;
                bus.alu_result = t[31:0];
                bus.alu_flags = {t[31], t[31:0] == 32'd0, bus.alu_a >= bus.alu_b,
                                 (bus.alu_a[31] != bus.alu_b[31]) && (t[31] != bus.alu_a[31])};
            end
            default: begin
                bus.alu_result = bus.alu_a & bus.alu_b;
                bus.alu_flags = {bus.alu_result[31], bus.alu_result == 32'd0, 2'b00};
            end
        endcase
    end

    always @(posedge clk) begin
        if (bus.rf_we) regs[bus.rf_waddr] <= bus.rf_wdata;
        if (bus.dmem_req && bus.dmem_ready && bus.dmem_we) dmem[bus.dmem_addr[7:0]] <= bus.dmem_wdata;
        if (bus.dmem_req && !bus.dmem_ready) dcnt <= dcnt + 1;
        else dcnt <= 0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [3:0] c, input logic [3:0] op, input logic s,
                                          input logic [3:0] d, input logic [3:0] a, input logic [3:0] b);
        return {c, op, s, d, a, b, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [3:0] c, input logic [3:0] op, input logic [15:0] imm);
        return {c, op, 1'b0, 4'd0, imm, 3'd0};
    endfunction

    // fetch log
    always @(negedge clk) begin
        if (rst_n) cyc++;
        if (bus.imem_req && bus.imem_ready) begin
            fa_q.push_back(bus.imem_addr);
            ft_q.push_back(cyc);
        end
    end

    // register write scoreboard
    always @(negedge clk) begin
        wb_t e;
        if (bus.rf_we) begin
            if (wb_q.size() == 0) begin
                check("wb_unexpected", 64'(bus.rf_waddr), 64'hFFFF);
            end else begin
                e = wb_q.pop_front();
                check("wb_addr", 64'(bus.rf_waddr), 64'(e.addr));
                check("wb_data", 64'(bus.rf_wdata), 64'(e.data));
                check("wb_flags", 64'(flags), 64'(e.fl));
            end
        end
    end

    // data access scoreboard, including address/data stability while waiting
    always @(negedge clk) begin
        dm_t e;
        if (bus.dmem_req) begin
            if (dreq_n == 0) begin
                d_addr0 = bus.dmem_addr;
                d_wdata0 = bus.dmem_wdata;
            end else begin
                check("dmem_addr_stable", 64'(bus.dmem_addr), 64'(d_addr0));
                check("dmem_wdata_stable", 64'(bus.dmem_wdata), 64'(d_wdata0));
            end
            dreq_n++;
            if (bus.dmem_ready) begin
                if (dm_q.size() == 0) begin
                    check("dmem_unexpected", 64'(bus.dmem_addr), 64'hFFFF_FFFF);
                end else begin
                    e = dm_q.pop_front();
                    check("dmem_we", 64'(bus.dmem_we), 64'(e.we));
                    check("dmem_addr", 64'(bus.dmem_addr), 64'(e.addr));
                    check("dmem_req_cycles", 64'(dreq_n), 64'(e.ncyc));
                    if (e.we) check("dmem_wdata", 64'(bus.dmem_wdata), 64'(e.data));
                end
                if (bus.dmem_we) n_store++;
                dreq_n = 0;
            end
        end else begin
            dreq_n = 0;
        end
    end

    initial begin
        logic [15:0] exp_fa [9];
        int exp_dt [8];
        logic [31:0] w;
        int reqs;
        int nfa;

        for (int i = 0; i < 65536; i++) imem[i] = enc_i(C_AL, O_HALT, 16'd0);

        // ---- program 1: ALU, conditional, load, store, branch, halt ----
        imem[0]  = enc_r(C_AL, O_ADD, 1'b1, 4'd3, 4'd1, 4'd2);
        imem[1]  = enc_r(C_AL, O_SUB, 1'b1, 4'd6, 4'd1, 4'd1);
        imem[2]  = enc_r(C_EQ, O_ADD, 1'b0, 4'd4, 4'd1, 4'd2);
        imem[3]  = enc_r(C_NE, O_ADD, 1'b0, 4'd7, 4'd1, 4'd2);
        imem[4]  = enc_r(C_AL, O_LDR, 1'b0, 4'd5, 4'd8, 4'd0);
        imem[5]  = enc_r(C_AL, O_STR, 1'b0, 4'd0, 4'd8, 4'd3);
        imem[6]  = enc_i(C_AL, O_B, 16'd3);
        imem[10] = enc_i(C_NV, O_HALT, 16'd0);
        imem[11] = enc_i(C_AL, O_HALT, 16'd0);
        dwait = 3;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_imem_req", 64'(bus.imem_req), 64'd0);
        check("rst_imem_addr", 64'(bus.imem_addr), 64'h0000);
        check("rst_dmem_req", 64'(bus.dmem_req), 64'd0);
        check("rst_dmem_we", 64'(bus.dmem_we), 64'd0);
        check("rst_rf_we", 64'(bus.rf_we), 64'd0);
        check("rst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
        check("rst_alu_a", 64'(bus.alu_a), 64'd0);
        check("rst_alu_op", 64'(bus.alu_op), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);

        wb_q.push_back('{addr: 4'd3, data: 32'd12, fl: 4'b0000});
        wb_q.push_back('{addr: 4'd6, data: 32'd0, fl: 4'b0110});
        wb_q.push_back('{addr: 4'd4, data: 32'd12, fl: 4'b0110});
        wb_q.push_back('{addr: 4'd5, data: 32'hDEADBEEF, fl: 4'b0110});
        dm_q.push_back('{we: 1'b0, addr: 16'h0040, data: 32'd0, ncyc: 8'd3});
        dm_q.push_back('{we: 1'b1, addr: 16'h0040, data: 32'd12, ncyc: 8'd3});

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300 && !halted; i++) @(negedge clk);
        check("halt_reached", 64'(halted), 64'd1);

        exp_fa = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd10, 16'd11};
        exp_dt = '{4, 4, 4, 2, 6, 5, 3, 2};
        check("fetch_count", 64'(fa_q.size()), 64'd9);
        nfa = (fa_q.size() < 9) ? fa_q.size() : 9;
        for (int i = 0; i < nfa; i++) check("fetch_addr", 64'(fa_q[i]), 64'(exp_fa[i]));
        for (int i = 0; i + 1 < nfa; i++) check("fetch_latency", 64'(ft_q[i+1] - ft_q[i]), 64'(exp_dt[i]));

        // halted core ignores stray ready and never requests again
        imem_force = 1'b1;
        reqs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.imem_req || bus.dmem_req) reqs++;
        end
        imem_force = 1'b0;
        check("halt_no_req", 64'(reqs), 64'd0);
        check("halt_stays", 64'(halted), 64'd1);
        check("halt_no_fetch", 64'(fa_q.size()), 64'd9);
        check("halt_flags", 64'(flags), 64'b0110);
        check("condfail_no_write_r7", 64'(regs[7]), 64'h77);
        check("store_data_in_mem", 64'(dmem[64]), 64'd12);
        check("p1_wb_drained", 64'(wb_q.size()), 64'd0);
        check("p1_dm_drained", 64'(dm_q.size()), 64'd0);

        // ---- program 2: branch wrap in both directions, B ignores s ----
        #2 rst_n = 1'b0;
        #1;
        check("rst2_flags", 64'(flags), 64'd0);
        check("rst2_halted", 64'(halted), 64'd0);
        check("rst2_imem_addr", 64'(bus.imem_addr), 64'h0000);
        fa_q.delete();
        ft_q.delete();
        imem[0] = enc_i(C_AL, O_B, 16'hFFFE);
        imem[16'hFFFF] = enc_i(C_AL, O_B, 16'h0001);
        w = enc_i(C_AL, O_B, 16'hFFFE);
        w[23] = 1'b1;
        imem[1] = w;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60 && fa_q.size() < 4; i++) @(negedge clk);
        check("wrap_fetch_count", 64'(fa_q.size() >= 4), 64'd1);
        if (fa_q.size() >= 4) begin
            check("wrap_fetch0", 64'(fa_q[0]), 64'h0000);
            check("wrap_back_to_ffff", 64'(fa_q[1]), 64'hFFFF);
            check("wrap_fwd_to_0001", 64'(fa_q[2]), 64'h0001);
            check("branch_to_0000", 64'(fa_q[3]), 64'h0000);
        end
        check("branch_keeps_flags", 64'(flags), 64'd0);

        // ---- program 3: reset in the middle of a store ----
        #2 rst_n = 1'b0;
        imem[0] = enc_r(C_AL, O_SUB, 1'b1, 4'd6, 4'd1, 4'd1);
        imem[1] = enc_r(C_AL, O_STR, 1'b0, 4'd0, 4'd8, 4'd3);
        dwait = 100;
        wb_q.push_back('{addr: 4'd6, data: 32'd0, fl: 4'b0110});
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30 && !bus.dmem_req; i++) @(negedge clk);
        check("str_req_seen", 64'(bus.dmem_req), 64'd1);
        repeat (2) @(negedge clk);
        check("str_pending_we", 64'(bus.dmem_we), 64'd1);
        check("str_pending_addr", 64'(bus.dmem_addr), 64'h0040);
        check("str_pending_flags", 64'(flags), 64'b0110);
        #2 rst_n = 1'b0;
        #1;
        check("abort_dmem_req", 64'(bus.dmem_req), 64'd0);
        check("abort_imem_req", 64'(bus.imem_req), 64'd0);
        check("abort_pc", 64'(bus.imem_addr), 64'h0000);
        check("abort_flags", 64'(flags), 64'd0);
        check("abort_rf_we", 64'(bus.rf_we), 64'd0);
        repeat (3) @(negedge clk);
        check("abort_no_store", 64'(n_store), 64'd1);
        check("abort_mem_unchanged", 64'(dmem[64]), 64'd12);
        check("p3_wb_drained", 64'(wb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
